// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and sizing helpers for the LIF frame sequencer
package lif_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} lif_state_e;

  function automatic int lif_inputs(input int n_stages);
    return 2 ** n_stages;
  endfunction

  // Frames narrower than a byte still occupy one LOAD cycle.
  function automatic int lif_bytes(input int n_stages);
    int b;
    b = (2 ** n_stages) / 8;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int lif_idx_w(input int n_stages);
    int b;
    b = lif_bytes(n_stages);
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

  localparam int LIF_N_STAGES = 5;
  localparam int LIF_INPUTS   = lif_inputs(LIF_N_STAGES);
  localparam int LIF_BYTES    = lif_bytes(LIF_N_STAGES);
  localparam int LIF_IDX_W    = lif_idx_w(LIF_N_STAGES);

endpackage

// File: rtl/lif_spike_counter.sv
// rtl/lif_spike_counter.sv - clear/enable counter holding the spikes of the last RUN phase
module lif_spike_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lif_frame_sequencer.sv
// rtl/lif_frame_sequencer.sv - serialises weight/input frames into the LIF neuron and runs integrate phases
module lif_frame_sequencer
  import lif_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int STEP_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_is_weights,
  input  logic [2**N_STAGES-1:0]   s_data,
  input  logic [STEP_W-1:0]        s_steps,
  output logic [7:0]               data_out,
  output logic                     load_weights,
  output logic                     run,
  input  logic                     spike,
  output logic                     busy,
  output logic                     done,
  output logic [STEP_W-1:0]        spike_count
);

  localparam int BYTES   = lif_bytes(N_STAGES);
  localparam int IDX_W   = lif_idx_w(N_STAGES);
  localparam int FRAME_W = 8 * BYTES;

  lif_state_e         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d, frame_in;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               is_w_q, is_w_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               lw_q, lw_d, run_q, run_d, busy_q, busy_d, done_q, done_d;
  logic               accept;

  assign s_ready  = (state_q == ST_IDLE);
  assign accept   = s_valid && s_ready;
  assign frame_in = FRAME_W'(s_data);

  // Outputs are decoded from the next state so they appear registered in the cycle they describe;
  // frame_q holds only the bytes not yet presented, top byte next.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    steps_d    = steps_q;
    idx_d      = idx_q;
    is_w_d     = is_w_q;
    data_out_d = data_out_q;
    lw_d       = lw_q;
    run_d      = run_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_LOAD;
          frame_d    = frame_in << 8;
          is_w_d     = s_is_weights;
          steps_d    = s_steps;
          idx_d      = IDX_W'(BYTES - 1);
          data_out_d = frame_in[FRAME_W-1 -: 8];
          lw_d       = s_is_weights;
          run_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_LOAD: begin
        if (idx_q != '0) begin
          idx_d      = idx_q - 1'b1;
          data_out_d = frame_q[FRAME_W-1 -: 8];
          frame_d    = frame_q << 8;
        end else begin
          data_out_d = 8'h00;
          lw_d       = 1'b0;
          run_d      = 1'b1;
          if (is_w_q || steps_q == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        steps_d = steps_q - 1'b1;
        if (steps_q == STEP_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      steps_q    <= '0;
      idx_q      <= '0;
      is_w_q     <= 1'b0;
      data_out_q <= 8'h00;
      lw_q       <= 1'b0;
      run_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      steps_q    <= steps_d;
      idx_q      <= idx_d;
      is_w_q     <= is_w_d;
      data_out_q <= data_out_d;
      lw_q       <= lw_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  lif_spike_counter #(.W(STEP_W)) u_spike_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept && !s_is_weights),
    .en_i    ((state_q == ST_RUN) && spike),
    .count_o (spike_count)
  );

  assign data_out     = data_out_q;
  assign load_weights = lw_q;
  assign run          = run_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
